// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid bit, flush, and a one-cycle multi-cycle state carry-back to EX.
// Optional bubble counter enabled by defining EX_MEM_PIPE_PERF_EN.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int CNT_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo
`ifdef EX_MEM_PIPE_PERF_EN
  ,
  output logic [31:0]         bubble_cnt
`endif
);

  logic                stall_here;
  logic                stall_down;
  logic                bubble;
  logic                stall_unused;

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                whilo_q, whilo_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign stall_here   = stall[STAGE];
  assign stall_down   = stall[STAGE+1];
  assign bubble       = !flush && stall_here && !stall_down;
  // Only two stall bits matter here; the rest are deliberately ignored.
  assign stall_unused = ^stall;

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = '0;
    cnt_d   = '0;
    if (flush || bubble) begin
      valid_d = 1'b0;
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      if (bubble) begin
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
    end else if (!stall_here) begin
      // An invalid slot must never produce a register write downstream.
      valid_d = ex_valid;
      wd_d    = ex_wd;
      wreg_d  = ex_valid && ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_valid && ex_whilo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_valid = valid_q;
  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

`ifdef EX_MEM_PIPE_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counts bubble edges only; flush and hold leave it alone, and it wraps freely.
  assign bubble_cnt_d = bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
